// File: rtl/gcd_datapath_pkg.sv
// Shared definitions for the GCD datapath and its controller: operand width
// and the operation-select encoding derived from the per-cycle strobes.
package gcd_datapath_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_SWAP = 2'd1,
    OP_SUB  = 2'd2,
    OP_HOLD = 2'd3
  } op_sel_e;

  // Strobe priority is SelectXY > swapFlag > subFlag > hold.
  function automatic op_sel_e decode_op(input logic select_xy,
                                        input logic swap_flag,
                                        input logic sub_flag);
    if (select_xy)      return OP_LOAD;
    else if (swap_flag) return OP_SWAP;
    else if (sub_flag)  return OP_SUB;
    else                return OP_HOLD;
  endfunction

endpackage

// File: rtl/gcd_alu.sv
// Combinational difference and status flags computed from the operand
// registers; the controller branches on ZEQ_Flag and LEQ_Flag.
module gcd_alu
  import gcd_datapath_pkg::*;
(
  input  logic [WIDTH-1:0] xr,
  input  logic [WIDTH-1:0] yr,
  output logic [WIDTH-1:0] z,
  output logic             zeq_flag,
  output logic             leq_flag
);

  // Wraps modulo 2^WIDTH; no borrow is reported.
  assign z        = xr - yr;
  assign zeq_flag = (yr == '0);
  // Strict compare: equal operands must subtract to zero rather than swap.
  assign leq_flag = (xr < yr);

endmodule

// File: rtl/gcd_datapath.sv
// Subtract/swap Euclidean GCD datapath: two enabled operand registers with
// next-value muxes. Purely strobe-driven; there is no handshake and every
// strobe takes effect at the next rising edge.
module gcd_datapath
  import gcd_datapath_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             SelectXY,
  input  logic             subFlag,
  input  logic             swapFlag,
  input  logic             loadXR,
  input  logic             loadYR,
  output logic [WIDTH-1:0] Z,
  output logic             ZEQ_Flag,
  output logic             LEQ_Flag,
  output logic [WIDTH-1:0] XR,
  output logic [WIDTH-1:0] YR
);

  op_sel_e          op;
  logic [WIDTH-1:0] xr_next;
  logic [WIDTH-1:0] yr_next;

  assign op = decode_op(SelectXY, swapFlag, subFlag);

  always_comb begin
    xr_next = XR;
    yr_next = YR;
    case (op)
      OP_LOAD: begin
        xr_next = X;
        yr_next = Y;
      end
      OP_SWAP: begin
        xr_next = YR;
        yr_next = XR;
      end
      OP_SUB: begin
        xr_next = Z;
        yr_next = YR;
      end
      default: begin
        xr_next = XR;
        yr_next = YR;
      end
    endcase
  end

  // Each register obeys only its own enable, so a one-sided swap copies.
  always_ff @(posedge clk) begin
    if (!rst) begin
      XR <= '0;
      YR <= '0;
    end else begin
      if (loadXR) XR <= xr_next;
      if (loadYR) YR <= yr_next;
    end
  end

  gcd_alu u_alu (
    .xr       (XR),
    .yr       (YR),
    .z        (Z),
    .zeq_flag (ZEQ_Flag),
    .leq_flag (LEQ_Flag)
  );

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed bench for gcd_datapath: one task per feature, inline checks
// against hand-computed register, difference and flag values.
module tb_gcd_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] X;
  logic [15:0] Y;
  logic        SelectXY;
  logic        subFlag;
  logic        swapFlag;
  logic        loadXR;
  logic        loadYR;
  logic [15:0] Z;
  logic        ZEQ_Flag;
  logic        LEQ_Flag;
  logic [15:0] XR;
  logic [15:0] YR;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gcd_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .X        (X),
    .Y        (Y),
    .SelectXY (SelectXY),
    .subFlag  (subFlag),
    .swapFlag (swapFlag),
    .loadXR   (loadXR),
    .loadYR   (loadYR),
    .Z        (Z),
    .ZEQ_Flag (ZEQ_Flag),
    .LEQ_Flag (LEQ_Flag),
    .XR       (XR),
    .YR       (YR)
  );

  task automatic drive(input logic sel, input logic sw, input logic sb,
                       input logic lx, input logic ly);
    SelectXY = sel;
    swapFlag = sw;
    subFlag  = sb;
    loadXR   = lx;
    loadYR   = ly;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    X = 16'd1234;
    Y = 16'd77;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    total++;
    if (XR !== 16'd0) $display("FAIL reset_xr: got %0d expected 0", XR);
    else passed++;
    total++;
    if (YR !== 16'd0) $display("FAIL reset_yr: got %0d expected 0", YR);
    else passed++;
    total++;
    if (Z !== 16'd0) $display("FAIL reset_z: got %0d expected 0", Z);
    else passed++;
    total++;
    if (ZEQ_Flag !== 1'b1) $display("FAIL reset_zeq: got %b expected 1", ZEQ_Flag);
    else passed++;
    total++;
    if (LEQ_Flag !== 1'b0) $display("FAIL reset_leq: got %b expected 0", LEQ_Flag);
    else passed++;
  endtask

  task automatic test_load();
    rst = 1'b1;
    X = 16'd25;
    Y = 16'd15;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    total++;
    if ({XR, YR, Z, ZEQ_Flag, LEQ_Flag} !== {16'd25, 16'd15, 16'd10, 1'b0, 1'b0})
      $display("FAIL load: got XR=%0d YR=%0d Z=%0d ZEQ=%b LEQ=%b expected 25/15/10/0/0",
               XR, YR, Z, ZEQ_Flag, LEQ_Flag);
    else passed++;
  endtask

  // Continues from the 25/15 load.
  task automatic test_gcd_sequence();
    logic        sw_tab  [7] = '{0, 1, 0, 1, 0, 0, 1};
    logic        sb_tab  [7] = '{1, 0, 1, 0, 1, 1, 0};
    logic [15:0] xr_tab  [7] = '{10, 15, 5, 10, 5, 0, 5};
    logic [15:0] yr_tab  [7] = '{15, 10, 10, 5, 5, 5, 0};
    logic [15:0] z_tab   [7] = '{65531, 5, 65531, 5, 0, 65531, 5};
    logic        zeq_tab [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic        leq_tab [7] = '{1, 0, 1, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, sw_tab[i], sb_tab[i], 1'b1, 1'b1);
      tick();
      total++;
      if ({XR, YR, Z, ZEQ_Flag, LEQ_Flag} !==
          {xr_tab[i], yr_tab[i], z_tab[i], zeq_tab[i], leq_tab[i]})
        $display("FAIL gcd_step%0d: got XR=%0d YR=%0d Z=%0d ZEQ=%b LEQ=%b expected %0d/%0d/%0d/%b/%b",
                 i, XR, YR, Z, ZEQ_Flag, LEQ_Flag,
                 xr_tab[i], yr_tab[i], z_tab[i], zeq_tab[i], leq_tab[i]);
      else passed++;
    end
    total++;
    if (XR !== 16'd5) $display("FAIL gcd_result: got %0d expected 5", XR);
    else passed++;
  endtask

  task automatic test_enable_gating();
    X = 16'd15;
    Y = 16'd10;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    total++;
    if ({XR, YR} !== {16'd15, 16'd10})
      $display("FAIL sub_gated: got XR=%0d YR=%0d expected 15/10", XR, YR);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    total++;
    if ({XR, YR} !== {16'd15, 16'd10})
      $display("FAIL hold: got XR=%0d YR=%0d expected 15/10", XR, YR);
    else passed++;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    total++;
    if ({XR, YR, Z, ZEQ_Flag, LEQ_Flag} !== {16'd10, 16'd10, 16'd0, 1'b0, 1'b0})
      $display("FAIL swap_one_way: got XR=%0d YR=%0d Z=%0d ZEQ=%b LEQ=%b expected 10/10/0/0/0",
               XR, YR, Z, ZEQ_Flag, LEQ_Flag);
    else passed++;
    X = 16'd1;
    Y = 16'd2;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    total++;
    if ({XR, YR} !== {16'd1, 16'd10})
      $display("FAIL load_xr_only: got XR=%0d YR=%0d expected 1/10", XR, YR);
    else passed++;
  endtask

  task automatic test_priority();
    X = 16'd100;
    Y = 16'd7;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    total++;
    if ({XR, YR} !== {16'd100, 16'd7})
      $display("FAIL prio_load: got XR=%0d YR=%0d expected 100/7", XR, YR);
    else passed++;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    total++;
    if ({XR, YR, Z, LEQ_Flag} !== {16'd7, 16'd100, 16'd65443, 1'b1})
      $display("FAIL prio_swap: got XR=%0d YR=%0d Z=%0d LEQ=%b expected 7/100/65443/1",
               XR, YR, Z, LEQ_Flag);
    else passed++;
  endtask

  task automatic test_wrap_and_repeat();
    X = 16'd5;
    Y = 16'd10;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    total++;
    if ({XR, YR, Z, LEQ_Flag} !== {16'd65531, 16'd10, 16'd65521, 1'b0})
      $display("FAIL sub_wrap: got XR=%0d YR=%0d Z=%0d LEQ=%b expected 65531/10/65521/0",
               XR, YR, Z, LEQ_Flag);
    else passed++;
    X = 16'd20;
    Y = 16'd6;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    total++;
    if (XR !== 16'd14) $display("FAIL repeat1: got %0d expected 14", XR);
    else passed++;
    tick();
    total++;
    if (XR !== 16'd8) $display("FAIL repeat2: got %0d expected 8", XR);
    else passed++;
    tick();
    total++;
    if ({XR, YR, Z, LEQ_Flag} !== {16'd2, 16'd6, 16'd65532, 1'b1})
      $display("FAIL repeat3: got XR=%0d YR=%0d Z=%0d LEQ=%b expected 2/6/65532/1",
               XR, YR, Z, LEQ_Flag);
    else passed++;
  endtask

  task automatic test_mid_reset();
    X = 16'd25;
    Y = 16'd15;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    total++;
    if ({XR, YR, Z, ZEQ_Flag, LEQ_Flag} !== {16'd0, 16'd0, 16'd0, 1'b1, 1'b0})
      $display("FAIL mid_reset: got XR=%0d YR=%0d Z=%0d ZEQ=%b LEQ=%b expected 0/0/0/1/0",
               XR, YR, Z, ZEQ_Flag, LEQ_Flag);
    else passed++;
    rst = 1'b1;
    X = 16'd9;
    Y = 16'd3;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    total++;
    if ({XR, YR, Z, ZEQ_Flag} !== {16'd9, 16'd3, 16'd6, 1'b0})
      $display("FAIL reload_after_reset: got XR=%0d YR=%0d Z=%0d ZEQ=%b expected 9/3/6/0",
               XR, YR, Z, ZEQ_Flag);
    else passed++;
  endtask

  initial begin
    rst = 1'b0;
    X = '0;
    Y = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_load();
    test_gcd_sequence();
    test_enable_gating();
    test_priority();
    test_wrap_and_repeat();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gcd_datapath.md
# gcd_datapath

Register-and-arithmetic datapath for a subtract/swap Euclidean GCD engine. It holds two operand registers, XR and YR, and loads, subtracts or swaps them under per-cycle control strobes from an external controller FSM. It returns the zero and ordering status flags the controller branches on. The GCD result is read from XR once YR reaches zero.

## Interface
- WIDTH, 16, operand/register width (all data ports below are WIDTH bits).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (sampled on rising clk edge).
- X  in  16  external operand A, loaded into XR.
- Y  in  16  external operand B, loaded into YR.
- SelectXY  in  1  load-select: registers take X/Y instead of internal results.
- subFlag  in  1  subtract operation: XR ← XR − YR.
- swapFlag  in  1  swap operation: XR ↔ YR.
- loadXR  in  1  write enable for XR.
- loadYR  in  1  write enable for YR.
- Z  out  16  combinational difference XR − YR (modulo 2^WIDTH).
- ZEQ_Flag  out  1  YR == 0 (GCD done).
- LEQ_Flag  out  1  XR < YR, strict unsigned (swap required).
- XR  out  16  current XR register value.
- YR  out  16  current YR register value.

## Operation
- All arithmetic is unsigned WIDTH-bit; subtraction wraps, with no borrow output.
- The next-value source is chosen with the priority SelectXY > swapFlag > subFlag > hold:
  - SelectXY=1: XR_next=X, YR_next=Y.
  - swapFlag=1: XR_next=YR, YR_next=XR (old values; a true simultaneous exchange).
  - subFlag=1: XR_next=XR−YR, YR_next=YR.
  - none asserted: XR_next=XR, YR_next=YR.
- A register updates only when its enable is 1. With the enable at 0 the register holds regardless of the selected operation.
- Swap with only one enable copies one way (e.g. loadXR=1, loadYR=0 gives XR←YR, YR unchanged).
- Z, ZEQ_Flag and LEQ_Flag are purely combinational from the XR/YR register outputs, never from X/Y.
- Equal operands give LEQ_Flag=0, so the controller subtracts to zero instead of swapping forever.
- Subtract when XR < YR is legal and wraps, e.g. 5−10 = 65531. The controller must avoid it.

## Timing
- Single-cycle operations: a strobe applied in cycle n is reflected on XR/YR/Z/flags right after rising edge n+1.
- Reset: when rst=0 at a rising edge, XR=0 and YR=0, overriding all strobes. This gives Z=0, ZEQ_Flag=1, LEQ_Flag=0.
- Reset mid-computation discards state at the next edge.
- There is no handshake. The controller owns sequencing, and flags are valid the same cycle registers change.
- A strobe held for several cycles repeats the operation every cycle (e.g. subFlag+loadXR held subtracts repeatedly).

## Structure
- Shared package: the WIDTH constant and the operation-select encoding (LOAD, SWAP, SUB, HOLD) used by both datapath and controller.
- One natural sub-module, gcd_alu: combinational subtractor (Z) plus comparators (ZEQ_Flag, LEQ_Flag).
- The top level holds the two enabled registers and the next-value muxes.

## Test plan
- Reset: rst=0 one edge with arbitrary strobes → XR=0, YR=0, Z=0, ZEQ_Flag=1, LEQ_Flag=0.
- Load: X=25, Y=15, SelectXY=1, loadXR=loadYR=1 → XR=25, YR=15, Z=10, ZEQ=0, LEQ=0.
- Full GCD(25,15), one op per cycle:
  - sub → XR=10
  - swap → 15/10
  - sub → 5/10
  - swap → 10/5
  - sub → 5/5
  - sub → 0/5, LEQ=1
  - swap → 5/0, ZEQ=1
  - Result XR=5.
- Enable gating: subFlag=1, loadXR=0 → XR/YR unchanged. Swap with loadXR=1, loadYR=0 from 15/10 → XR=10, YR=10.
- Priority: SelectXY, swapFlag, subFlag all 1 with both enables → X/Y loaded. swapFlag+subFlag → swap only.
- Mid-operation reset: rst=0 after loading 25/15 → next edge 0/0; subsequent load works normally.
